io_xbar_link_fifo: RTL and testbench
====================================

// Module: io_xbar_link_fifo
// PURPOSE
//  Elastic val/rdy FIFO directly upstream of the IO crossbar bus-inversion stage.
//  - Absorbs backpressure between a crossbar port and the outgoing link.
//  - Presents registered, glitch-free data to the inverter, so the inverted bus never toggles mid-cycle.
//  - Exposes an occupancy count for link flow monitoring.
// PARAMETERS
//  WIDTH       8   data bus width in bits; matches the downstream inverter width
//  LOG2_DEPTH  2   log2 of FIFO depth; DEPTH = 1<<LOG2_DEPTH (4); legal range 1..6
// PORTS
//  clk         in   1             single clock; all state changes on rising edge
//  rst_n       in   1             asynchronous, active-low reset
//  in_data     in   WIDTH         write data from crossbar port
//  in_val      in   1             write request
//  in_rdy      out  1             FIFO can accept; equals !full
//  out_data    out  WIDTH         head-of-queue data; feeds the bus-inversion stage
//  out_val     out  1             head entry valid; equals !empty (see CONFIGURATION)
//  out_rdy     in   1             downstream accepts the head
//  count       out  LOG2_DEPTH+1  number of stored entries, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst_n=0, async assert, sync deassert handled externally):
//    - wr_ptr=0, rd_ptr=0, count=0, in_rdy=1, out_val=0.
//    - out_data=0; the storage array is not reset.
//  - Write fires when in_val&in_rdy; entry stored at wr_ptr, wr_ptr+1.
//  - Read fires when out_val&out_rdy; rd_ptr+1.
//  - Pointers are LOG2_DEPTH+1 bits; index = low bits; natural wrap DEPTH-1 -> 0.
//  - full  = ptr MSBs differ and low bits equal; empty = pointers equal.
//  - count = wr_ptr - rd_ptr, modulo 2^(LOG2_DEPTH+1); registered-equivalent, never exceeds DEPTH.
//  - Latency: word written in cycle N is visible on out_data/out_val in cycle N+1.
//  - out_data = storage[rd_ptr] whenever out_val=1; held stable until read fires.
//  - Simultaneous write and read:
//    - not full, not empty: both fire, count unchanged.
//    - full: in_rdy=0, so no write that cycle even if the read fires; in_rdy rises the next cycle.
//    - empty: no read; the write lands; count goes 0 -> 1.
//  - in_val asserted while full: ignored, no state change, no data loss upstream.
//    - Upstream must hold in_data stable until the write fires.
//  - out_val never drops without a read firing; out_data never changes while out_val=1 and out_rdy=0.
//  - Reset mid-operation: all contents discarded; outputs return to reset values
//    asynchronously; no spurious out_val on release.
// CONFIGURATION
//  IO_XBAR_LINK_FIFO_BYPASS_EN
//   - defined: when the FIFO is empty and in_val=1:
//     - out_val=1 and out_data=in_data combinationally.
//     - If out_rdy=1, the word passes with zero latency and is not stored (count stays 0).
//     - If out_rdy=0, the word is stored normally.
//     - This adds a comb path in_val/in_data -> out_val/out_data.
//   - undefined: no comb paths from inputs to outputs; minimum latency 1 cycle
//     (behaviour as above).
// TESTING
//  1. Reset: hold rst_n=0 with in_val=1 -> in_rdy=1, out_val=0, count=0, out_data=0;
//     after release, no out_val until a write fires.
//  2. Fill/drain: out_rdy=0, write 0x11..0x44 -> count=4, in_rdy=0 after 4th write;
//     5th word 0x55 held, not stored; out_rdy=1 -> reads 0x11,0x22,0x33,0x44 in order;
//     in_rdy=1 the cycle after the first read.
//  3. Full + simultaneous: full FIFO, in_val=1, out_rdy=1 -> read of 0x11 fires,
//     0x55 not stored that cycle; count 4->3; next cycle 0x55 accepted, count=4.
//  4. Wrap: 10 back-to-back writes with 1-cycle-lagged reads (values 0x00..0x09)
//     -> outputs 0x00..0x09 in order, count never >2, pointers wrap cleanly.
//  5. Async reset mid-stream: count=3, pulse rst_n low between edges
//     -> out_val=0, count=0 immediately; the old data never appears after release.
//  6. Bypass (macro defined): empty FIFO, in_val=1, in_data=0xA5, out_rdy=1
//     -> out_val=1, out_data=0xA5 same cycle, count stays 0;
//     without macro: out_val=1 the next cycle, count=1 for one cycle.

Source files
------------

// File: rtl/io_xbar_link_fifo.sv
// Elastic val/rdy FIFO feeding the IO crossbar bus-inversion stage; head data is registered.
// Optional zero-latency pass-through when empty: define IO_XBAR_LINK_FIFO_BYPASS_EN.
module io_xbar_link_fifo #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_val,
    output logic                  in_rdy,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [LOG2_DEPTH:0]   count
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int PW    = LOG2_DEPTH + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full, empty, wr_fire, rd_fire;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[LOG2_DEPTH] != rd_ptr_q[LOG2_DEPTH]) &&
                    (wr_ptr_q[LOG2_DEPTH-1:0] == rd_ptr_q[LOG2_DEPTH-1:0]);
    assign in_rdy = !full;
    assign count  = wr_ptr_q - rd_ptr_q;

`ifdef IO_XBAR_LINK_FIFO_BYPASS_EN
    logic bypass;

    // Gated by rst_n so the pass-through path cannot assert out_val while in reset.
    assign bypass   = empty && in_val && rst_n;
    assign out_val  = !empty || bypass;
    assign out_data = bypass ? in_data : out_data_q;
    assign wr_fire  = in_val && !full && !(bypass && out_rdy);
    assign rd_fire  = !empty && out_rdy;
`else
    assign out_val  = !empty;
    assign out_data = out_data_q;
    assign wr_fire  = in_val && !full;
    assign rd_fire  = !empty && out_rdy;
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(wr_fire);
        rd_ptr_d   = rd_ptr_q + PW'(rd_fire);
        out_data_d = out_data_q;
        // Preload the next head; it is the incoming word when that slot is written this cycle.
        if (wr_ptr_d != rd_ptr_d) begin
            if (wr_fire && (rd_ptr_d == wr_ptr_q)) begin
                out_data_d = in_data;
            end else begin
                out_data_d = mem_q[rd_ptr_d[LOG2_DEPTH-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_data_q <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[LOG2_DEPTH-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_io_xbar_link_fifo.sv
// Directed bench for io_xbar_link_fifo with a queue scoreboard and a decoupled output monitor.
module tb_io_xbar_link_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] out_data;
    logic       out_val;
    logic       out_rdy;
    logic [2:0] count;

    int         checks = 0;
    int         errors = 0;
    int         max_cnt = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;

    io_xbar_link_fifo #(.WIDTH(8), .LOG2_DEPTH(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: every accepted output word must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_val === 1'b1 && out_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read actual=0x%0h required=no_word at %0t", out_data, $time);
            end else begin
                exp_v = exp_q.pop_front();
                chk("read_data", {24'd0, out_data}, {24'd0, exp_v});
            end
        end
        if (rst_n === 1'b1 && int'(count) > max_cnt) max_cnt = int'(count);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (count == 3'd0 && out_val == 1'b0) done = 1'b1;
        end
        chk("drain_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with in_val held high
        rst_n = 1'b0; in_val = 1'b1; in_data = 8'h77; out_rdy = 1'b0;
        @(negedge clk);
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_out_val", out_val, 0);
        chk("rst_count", count, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; in_val = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_out_val", out_val, 0);
        chk("post_rst_count", count, 0);

        // Fill with out_rdy low
        cyc();
        for (int i = 0; i < 4; i++) begin
            in_val = 1'b1;
            in_data = 8'(8'h11 * (i + 1));
            exp_q.push_back(in_data);
            @(negedge clk);
            chk("fill_in_rdy", in_rdy, 1);
            cyc();
        end
        in_data = 8'h55;
        @(negedge clk);
        chk("full_count", count, 4);
        chk("full_in_rdy", in_rdy, 0);
        chk("full_out_val", out_val, 1);
        chk("full_out_data", out_data, 8'h11);
        cyc();
        @(negedge clk);
        chk("full_hold_count", count, 4);
        chk("full_hold_data", out_data, 8'h11);

        // Full with simultaneous read: write must not land this cycle
        cyc();
        out_rdy = 1'b1;
        exp_q.push_back(8'h55);
        @(negedge clk);
        chk("simul_in_rdy", in_rdy, 0);
        cyc();
        out_rdy = 1'b0;
        @(negedge clk);
        chk("after_read_count", count, 3);
        chk("after_read_in_rdy", in_rdy, 1);
        cyc();
        in_val = 1'b0;
        @(negedge clk);
        chk("refill_count", count, 4);
        chk("refill_head", out_data, 8'h22);
        cyc();
        out_rdy = 1'b1;
        wait_drain();
        chk("drain_queue_empty", exp_q.size(), 0);

        // Back-to-back writes with continuous reads, pointers wrap
        cyc();
        max_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            in_val = 1'b1;
            in_data = 8'(i);
            exp_q.push_back(in_data);
            cyc();
        end
        in_val = 1'b0;
        wait_drain();
        chk("wrap_max_count_le2", {31'd0, (max_cnt <= 2)}, 1);
        chk("wrap_queue_empty", exp_q.size(), 0);

        // Async reset with three words stored
        cyc();
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_val = 1'b1;
            in_data = 8'(8'hA1 + i);
            exp_q.push_back(in_data);
            cyc();
        end
        in_val = 1'b0;
        @(negedge clk);
        chk("pre_rst_count", count, 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_val", out_val, 0);
        chk("async_rst_count", count, 0);
        chk("async_rst_out_data", out_data, 0);
        chk("async_rst_in_rdy", in_rdy, 1);
        exp_q.delete();
        #1 rst_n = 1'b1;
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_async_out_val", out_val, 0);
        end

        // Single word into an empty FIFO with out_rdy high
        cyc();
        in_val = 1'b1; in_data = 8'hA5; out_rdy = 1'b1;
        exp_q.push_back(8'hA5);
        @(negedge clk);
`ifdef IO_XBAR_LINK_FIFO_BYPASS_EN
        chk("byp_out_val", out_val, 1);
        chk("byp_out_data", out_data, 8'hA5);
        chk("byp_count", count, 0);
        cyc();
        in_val = 1'b0;
        @(negedge clk);
        chk("byp_after_count", count, 0);
        chk("byp_after_out_val", out_val, 0);
`else
        chk("nobyp_out_val0", out_val, 0);
        chk("nobyp_count0", count, 0);
        cyc();
        in_val = 1'b0;
        @(negedge clk);
        chk("nobyp_out_val1", out_val, 1);
        chk("nobyp_out_data1", out_data, 8'hA5);
        chk("nobyp_count1", count, 1);
        cyc();
        @(negedge clk);
        chk("nobyp_count2", count, 0);
        chk("nobyp_out_val2", out_val, 0);
`endif
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
